// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
//
// Purpose: arbiter state encoding, requester index constants and the default
// fetch starvation limit, shared by the top, its counter and the bench.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'b00,
        FORCE = 2'b01,
        BURST = 2'b10
    } arb_state_t;

    // Bit positions inside the one-hot grant and read-tag vectors.
    localparam int REQ_DATA  = 0;
    localparam int REQ_FETCH = 1;
    localparam int REQ_LD    = 2;
    localparam int NUM_REQ   = 3;

    localparam int DEFAULT_STARVE_LIMIT = 3;
    localparam int STARVE_W             = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus bundle for the memory port arbiter
//
// Purpose: groups the three requester handshakes, the memory port and the
// debug starvation count.
// Modports:
//   master - requester/memory side: drives requests and mem_rdata
//   slave  - arbiter side: drives grants, rvalids, memory command, rdata, starve_cnt
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          data_req;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_gnt;
    logic          data_rvalid;

    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;

    logic          ld_req;
    logic          ld_we;
    logic          ld_last;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rdata;
    logic [3:0]    starve_cnt;

    modport master (
        output data_req, data_we, data_addr, data_wdata,
        output fetch_req, fetch_addr,
        output ld_req, ld_we, ld_last, ld_addr, ld_wdata,
        output mem_rdata,
        input  data_gnt, data_rvalid, fetch_gnt, fetch_rvalid, ld_gnt, ld_rvalid,
        input  mem_addr, mem_we, mem_wdata, rdata, starve_cnt
    );

    modport slave (
        input  data_req, data_we, data_addr, data_wdata,
        input  fetch_req, fetch_addr,
        input  ld_req, ld_we, ld_last, ld_addr, ld_wdata,
        input  mem_rdata,
        output data_gnt, data_rvalid, fetch_gnt, fetch_rvalid, ld_gnt, ld_rvalid,
        output mem_addr, mem_we, mem_wdata, rdata, starve_cnt
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating fetch starvation counter
//
// Purpose: counts consecutive denied fetch cycles.
// Ports:
//   clock, reset  - clock, asynchronous active-high reset
//   inc           - fetch was denied this cycle
//   clr           - fetch was granted or not requesting this cycle
//   hold          - freeze the count (loader burst)
//   count         - current count
//   at_limit      - count after the coming edge equals LIMIT
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    input  logic                hold,
    output logic [STARVE_W-1:0] count,
    output logic                at_limit
);

    logic [STARVE_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (!hold) begin
            if (clr) begin
                count_next = '0;
            end else if (inc && (count != '1)) begin
                count_next = count + 1'b1;
            end
        end
    end

    // Compared against the next value so the arbiter can enter FORCE on the
    // same edge at which the count reaches the limit.
    assign at_limit = (count_next == STARVE_W'(LIMIT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-way arbiter for a single-port unified memory
//
// Purpose: grants one of data stage, instruction fetch or program loader per
// cycle onto a single-port synchronous memory, with fetch anti-starvation,
// locked loader bursts and one-cycle tagged read responses.
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-high
//   bus    - mem_port_arbiter_if.slave: requester handshakes, memory port,
//            rdata pass-through and starve_cnt debug output
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t state, state_next;

    logic [NUM_REQ-1:0]  pick;
    logic [NUM_REQ-1:0]  gnt;
    logic [NUM_REQ-1:0]  rd_issue;
    logic [NUM_REQ-1:0]  tag_q;
    logic [AW-1:0]       addr_q;
    logic [AW-1:0]       addr_mux;
    logic [DW-1:0]       wdata_mux;
    logic                we_mux;
    logic                starve_inc;
    logic                starve_clr;
    logic                starve_hold;
    logic                starve_at_limit;
    logic [STARVE_W-1:0] starve_count;

    // Normal priority: data > fetch > loader.
    always_comb begin
        pick = '0;
        if (bus.data_req) begin
            pick[REQ_DATA] = 1'b1;
        end else if (bus.fetch_req) begin
            pick[REQ_FETCH] = 1'b1;
        end else if (bus.ld_req) begin
            pick[REQ_LD] = 1'b1;
        end
    end

    // A FORCE cycle without a fetch request, and a BURST cycle where the
    // loader has let go, both fall back to normal priority for that cycle.
    always_comb begin
        gnt = '0;
        case (state)
            ARB: gnt = pick;
            FORCE: begin
                if (bus.fetch_req) begin
                    gnt[REQ_FETCH] = 1'b1;
                end else begin
                    gnt = pick;
                end
            end
            BURST: begin
                if (bus.ld_req) begin
                    gnt[REQ_LD] = 1'b1;
                end else begin
                    gnt = pick;
                end
            end
            default: gnt = '0;
        endcase
        if (reset) begin
            gnt = '0;
        end
    end

    always_comb begin
        starve_hold = (state == BURST);
        starve_clr  = gnt[REQ_FETCH] | ~bus.fetch_req;
        starve_inc  = (state == ARB) & bus.fetch_req & ~gnt[REQ_FETCH];
    end

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .hold     (starve_hold),
        .count    (starve_count),
        .at_limit (starve_at_limit)
    );

    always_comb begin
        state_next = state;
        case (state)
            ARB: begin
                if (gnt[REQ_LD] && !bus.ld_last) begin
                    state_next = BURST;
                end else if (starve_at_limit) begin
                    state_next = FORCE;
                end
            end
            FORCE: state_next = ARB;
            BURST: begin
                if (!bus.ld_req || bus.ld_last) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    // Idle cycles keep the last issued address on the port.
    always_comb begin
        addr_mux  = addr_q;
        we_mux    = 1'b0;
        wdata_mux = '0;
        if (gnt[REQ_DATA]) begin
            addr_mux  = bus.data_addr;
            we_mux    = bus.data_we;
            wdata_mux = bus.data_wdata;
        end else if (gnt[REQ_FETCH]) begin
            addr_mux  = bus.fetch_addr;
        end else if (gnt[REQ_LD]) begin
            addr_mux  = bus.ld_addr;
            we_mux    = bus.ld_we;
            wdata_mux = bus.ld_wdata;
        end
    end

    always_comb begin
        rd_issue            = '0;
        rd_issue[REQ_DATA]  = gnt[REQ_DATA] & ~bus.data_we;
        rd_issue[REQ_FETCH] = gnt[REQ_FETCH];
        rd_issue[REQ_LD]    = gnt[REQ_LD] & ~bus.ld_we;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ARB;
            addr_q <= '0;
            tag_q  <= '0;
        end else begin
            state  <= state_next;
            tag_q  <= rd_issue;
            if (|gnt) begin
                addr_q <= addr_mux;
            end
        end
    end

    assign bus.data_gnt     = gnt[REQ_DATA];
    assign bus.fetch_gnt    = gnt[REQ_FETCH];
    assign bus.ld_gnt       = gnt[REQ_LD];
    assign bus.data_rvalid  = tag_q[REQ_DATA];
    assign bus.fetch_rvalid = tag_q[REQ_FETCH];
    assign bus.ld_rvalid    = tag_q[REQ_LD];
    assign bus.mem_addr     = addr_mux;
    assign bus.mem_we       = we_mux;
    assign bus.mem_wdata    = wdata_mux;
    assign bus.rdata        = bus.mem_rdata;
    assign bus.starve_cnt   = starve_count;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int LIMIT = 3;

    logic clock;
    logic reset;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         who;
        logic [7:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Stimulus for the next cycle.
    logic       s_reset, s_dreq, s_dwe, s_freq, s_lreq, s_lwe, s_llast;
    logic [7:0] s_daddr, s_dwd, s_faddr, s_laddr, s_lwd;

    // Reference model state.
    logic [7:0] ref_mem [256];
    int         denied;
    bit         locked;
    bit         fturn;
    logic [7:0] last_addr;
    int         last_win;

    // Memory behind the port: one-cycle read latency.
    logic [7:0]   mem [256];
    logic [255:0] mem_wr;
    logic         mem_clear;
    logic [7:0]   mem_rdata_q;

    function automatic logic [7:0] mem_init(input logic [7:0] a);
        return (a * 8'd7) + 8'd3;
    endfunction

    always @(posedge clock) begin
        if (mem_clear) begin
            mem_wr <= '0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr]    <= bus.mem_wdata;
            mem_wr[bus.mem_addr] <= 1'b1;
        end
        mem_rdata_q <= mem_wr[bus.mem_addr] ? mem[bus.mem_addr] : mem_init(bus.mem_addr);
    end
    assign bus.mem_rdata = mem_rdata_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        denied    = 0;
        locked    = 0;
        fturn     = 0;
        last_addr = 8'h00;
        exp_q.delete();
    endtask

    task automatic idle_all();
        s_dreq = 0; s_dwe = 0; s_freq = 0; s_lreq = 0; s_lwe = 0; s_llast = 0;
    endtask

    // One cycle: drive, compare against the model, advance the model.
    task automatic step();
        int         win;
        int         nd;
        bit         nl, nf, we;
        logic [7:0] a, wd;
        resp_t      r;
        @(negedge clock);
        reset           = s_reset;
        bus.data_req    = s_dreq;
        bus.data_we     = s_dwe;
        bus.data_addr   = s_daddr;
        bus.data_wdata  = s_dwd;
        bus.fetch_req   = s_freq;
        bus.fetch_addr  = s_faddr;
        bus.ld_req      = s_lreq;
        bus.ld_we       = s_lwe;
        bus.ld_last     = s_llast;
        bus.ld_addr     = s_laddr;
        bus.ld_wdata    = s_lwd;
        #1;
        if (s_reset) model_reset();
        win = -1;
        if (!s_reset) begin
            if (locked && s_lreq)      win = REQ_LD;
            else if (fturn && s_freq)  win = REQ_FETCH;
            else if (s_dreq)           win = REQ_DATA;
            else if (s_freq)           win = REQ_FETCH;
            else if (s_lreq)           win = REQ_LD;
        end
        chk("data_gnt", bus.data_gnt, win == REQ_DATA);
        chk("fetch_gnt", bus.fetch_gnt, win == REQ_FETCH);
        chk("ld_gnt", bus.ld_gnt, win == REQ_LD);
        chk("starve_cnt", bus.starve_cnt, denied);
        a = 8'h00; we = 0; wd = 8'h00;
        if (win == REQ_DATA)  begin a = s_daddr; we = s_dwe; wd = s_dwd; end
        if (win == REQ_FETCH) begin a = s_faddr; end
        if (win == REQ_LD)    begin a = s_laddr; we = s_lwe; wd = s_lwd; end
        if (win >= 0) begin
            chk("mem_addr", bus.mem_addr, a);
            chk("mem_we", bus.mem_we, we);
            if (we) begin
                chk("mem_wdata", bus.mem_wdata, wd);
                ref_mem[a] = wd;
            end else begin
                r.who  = win;
                r.data = ref_mem[a];
                exp_q.push_back(r);
            end
            last_addr = a;
        end else begin
            chk("idle_mem_addr", bus.mem_addr, last_addr);
            chk("idle_mem_we", bus.mem_we, 0);
        end
        if (!s_reset) begin
            if (locked) nd = denied;
            else if (win == REQ_FETCH || !s_freq) nd = 0;
            else nd = (denied < 15) ? denied + 1 : 15;
            nl = locked ? (s_lreq && !s_llast) : (!fturn && win == REQ_LD && !s_llast);
            nf = !locked && !fturn && !nl && (nd == LIMIT);
            denied = nd;
            locked = nl;
            fturn  = nf;
        end
        last_win = win;
    endtask

    // Response monitor: pops the scoreboard whenever a response is due or shown.
    initial begin
        logic [2:0] got, want;
        resp_t      r;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                got  = {bus.ld_rvalid, bus.fetch_rvalid, bus.data_rvalid};
                want = '0;
                r.who  = 0;
                r.data = 8'h00;
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    want[r.who] = 1'b1;
                end
                if (got != 0 || want != 0) begin
                    chk("rvalid_tag", got, want);
                    if (want != 0) chk("rdata", bus.rdata, r.data);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(8'(i));
        model_reset();
        last_win  = -1;
        mem_clear = 1'b1;
        reset     = 1'b1;
        idle_all();
        s_reset = 1; s_daddr = 0; s_dwd = 0; s_faddr = 0; s_laddr = 0; s_lwd = 0;

        // Reset state: requests present but nothing may be granted.
        s_dreq = 1; s_freq = 1; s_lreq = 1;
        step();
        chk("reset_rvalids", {bus.ld_rvalid, bus.fetch_rvalid, bus.data_rvalid}, 0);
        step();
        mem_clear = 1'b0;
        s_reset = 0;
        idle_all();
        step();

        // Fetch-only reads at 0x10 and 0x11.
        s_freq = 1; s_faddr = 8'h10; step();
        s_faddr = 8'h11; step();
        idle_all(); step(); step();

        // Data loads held against fetch: forced fetch on the fourth cycle.
        s_dreq = 1; s_dwe = 0; s_daddr = 8'h80; s_freq = 1; s_faddr = 8'h30;
        for (int i = 0; i < 5; i++) begin
            step();
            if (last_win == REQ_FETCH) s_freq = 0;
        end
        idle_all(); step(); step();

        // Store then load the same address.
        s_dreq = 1; s_dwe = 1; s_daddr = 8'h20; s_dwd = 8'h5A; step();
        s_dwe = 0; step();
        idle_all(); step(); step();

        // Four-beat loader burst, fetch raised after beat 1.
        s_lreq = 1; s_lwe = 1;
        for (int i = 0; i < 4; i++) begin
            s_laddr = 8'(i); s_lwd = 8'(8'hA0 + i); s_llast = (i == 3);
            if (i >= 1) begin s_freq = 1; s_faddr = 8'h02; end
            step();
        end
        s_lreq = 0; s_llast = 0; step();
        idle_all(); step(); step();

        // Burst abandoned after two beats with data waiting.
        s_lreq = 1; s_lwe = 1; s_llast = 0;
        for (int i = 0; i < 2; i++) begin
            s_laddr = 8'(8'h08 + i); s_lwd = 8'(8'hC0 + i);
            step();
        end
        s_lreq = 0; s_dreq = 1; s_dwe = 0; s_daddr = 8'h08; step();
        idle_all(); step(); step();

        // Reset pulsed right after a fetch read issues.
        s_freq = 1; s_faddr = 8'h40; step();
        idle_all();
        @(posedge clock);
        reset = 1'b1;
        s_reset = 1;
        model_reset();
        #2;
        chk("rst_fetch_rvalid", bus.fetch_rvalid, 0);
        chk("rst_starve", bus.starve_cnt, 0);
        s_dreq = 1; s_freq = 1; s_lreq = 1; s_lwe = 1;
        step(); step();
        s_reset = 0; idle_all();
        s_freq = 1; s_faddr = 8'h41; step();
        idle_all(); step(); step();

        // Randomised traffic; ungranted requesters hold their request.
        for (int i = 0; i < 600; i++) begin
            if (!s_dreq || last_win == REQ_DATA) begin
                s_dreq  = ($urandom_range(0, 99) < 45);
                s_dwe   = 1'($urandom_range(0, 1));
                s_daddr = 8'($urandom_range(0, 15));
                s_dwd   = 8'($urandom);
            end
            if (!s_freq || last_win == REQ_FETCH) begin
                s_freq  = ($urandom_range(0, 99) < 50);
                s_faddr = 8'($urandom_range(0, 15));
            end
            if (!s_lreq || last_win == REQ_LD) begin
                s_lreq  = ($urandom_range(0, 99) < 35);
                s_lwe   = 1'($urandom_range(0, 1));
                s_llast = ($urandom_range(0, 3) == 0);
                s_laddr = 8'($urandom_range(0, 15));
                s_lwd   = 8'($urandom);
            end
            step();
        end
        idle_all(); step(); step(); step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-port synchronous unified memory between three requesters: the pipeline's data stage (load/store), instruction fetch, and a program loader used while the CPU is held.
- Grants are combinational in the request cycle. Ungranted requesters see gnt=0 and must hold their request, which the controller treats as a stall.
- Includes a fetch anti-starvation counter and a locked loader burst mode.
- Returns read responses one cycle after issue, tagged to the requester.

Parameters:
AW, 8, address width
DW, 8, data width
STARVE_LIMIT, 3, consecutive denied fetch cycles before fetch is forced ahead of data (range 1..15)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
data_req  in  1  data-stage access request
data_we  in  1  1=store, 0=load
data_addr  in  AW  data address
data_wdata  in  DW  store data
data_gnt  out  1  data access issued this cycle
data_rvalid  out  1  rdata holds data-stage load result
fetch_req  in  1  instruction fetch request (read only)
fetch_addr  in  AW  fetch address
fetch_gnt  out  1  fetch issued this cycle
fetch_rvalid  out  1  rdata holds fetched instruction
ld_req  in  1  loader request
ld_we  in  1  loader write enable
ld_last  in  1  final beat of loader burst
ld_addr  in  AW  loader address
ld_wdata  in  DW  loader write data
ld_gnt  out  1  loader beat issued this cycle
ld_rvalid  out  1  rdata holds loader readback
mem_addr  out  AW  memory address
mem_we  out  1  memory write strobe
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one cycle after a read issue
rdata  out  DW  combinational pass-through of mem_rdata
starve_cnt  out  4  current fetch starvation count (debug)

Behaviour:
- Reset values:
  - State is ARB and starve_cnt is 0.
  - All *_rvalid outputs are 0.
  - While reset is high, all *_gnt outputs and mem_we are forced to 0.
- States:
  - ARB: normal arbitration.
  - FORCE: fetch wins this cycle.
  - BURST: loader owns the port.
- ARB priority is data > fetch > loader. The loader is granted only when data_req=0 and fetch_req=0.
- FORCE priority is fetch > data > loader.
- FORCE is entered when starve_cnt == STARVE_LIMIT at a clock edge. It lasts exactly one cycle and then returns to ARB. If fetch_req has dropped by then, the arbiter falls back to ARB priority for that cycle.
- starve_cnt:
  - Increments (saturating at 15) on every ARB cycle with fetch_req=1 and fetch_gnt=0.
  - Clears on any fetch grant or any cycle with fetch_req=0.
  - Holds its value during BURST.
- BURST:
  - Entered when the loader is granted in ARB with ld_last=0.
  - Only the loader may be granted; data_gnt=fetch_gnt=0 even if requesting.
  - Exits to ARB after a granted beat with ld_last=1, or on any cycle with ld_req=0 (no grant that cycle).
  - A loader grant in ARB with ld_last=1 is a single beat and does not enter BURST.
- Exactly one grant at most per cycle. mem_addr, mem_we and mem_wdata are muxed from the granted requester. With no grant, mem_we=0 and mem_addr holds the last issued address.
- Read tag:
  - A registered one-hot tag is set when a granted access has we=0. On the next cycle the matching *_rvalid=1.
  - Writes produce no rvalid.
  - Back-to-back reads give rvalid every cycle, each tagged to its own issuer.
- Reset asserted mid-operation clears the tag and state immediately. An in-flight read is dropped with no rvalid.

Decomposition:
- A shared package holds:
  - the state encoding (ARB=2'b00, FORCE=2'b01, BURST=2'b10);
  - requester index constants (REQ_DATA=0, REQ_FETCH=1, REQ_LD=2);
  - the default STARVE_LIMIT.
- One sub-module, arb_starve_counter: a 4-bit saturating counter with inc, clr and hold inputs and a terminal-compare output at STARVE_LIMIT.
- Grant mux, FSM and read tag remain in the top module.

Test Plan:
- Fetch-only reads, addr 0x10 then 0x11 -> fetch_gnt=1 both cycles; fetch_rvalid=1 in cycles 2 and 3 with rdata equal to mem[0x10] and mem[0x11].
- data_req (load 0x80) and fetch_req together, STARVE_LIMIT=3, data held high for 5 cycles:
  - data_gnt in cycles 1-3;
  - starve_cnt reaches 3;
  - fetch_gnt in cycle 4 (FORCE), then data_gnt in cycle 5;
  - starve_cnt=0 after cycle 4.
- Store 0x5A to 0x20 followed by a data load from 0x20 -> mem_we=1 in cycle 1 and no rvalid for it; data_rvalid in cycle 3 with rdata=0x5A.
- Loader burst of 4 writes (0x00..0x03, ld_last on beat 4) with fetch_req raised after beat 1:
  - ld_gnt on all 4 beats and fetch_gnt=0 throughout;
  - starve_cnt frozen at 0;
  - fetch granted the cycle after beat 4.
- Loader burst with ld_req dropped after beat 2 -> ld_gnt=0 in the drop cycle, return to ARB, and a pending data_req is granted that same cycle.
- reset pulsed the cycle after a fetch read issue:
  - fetch_rvalid stays 0 and starve_cnt=0;
  - all gnt and mem_we are 0 while reset is high;
  - normal grants resume the first cycle after release.
